// File: rtl/instr_aligner_if.sv
// instr_aligner_if
//   Bundles the fetch bus, the redirect input and the decode-side handshake
//   of the instruction aligner.
//   master : the aligner side (drives fetch request and instruction outputs)
//   slave  : the environment side (bus, redirect source, decode stage)
//   Signals:
//     flush_i / flush_pc_i          redirect request and target PC
//     fetch_req_o / fetch_addr_o    word-aligned fetch request
//     fetch_ack_i / fetch_data_i    fetch completion and returned word
//     instr_valid_o / instr_ready_i decode handshake
//     instr_o / instr_pc_o / instr_is_c_o  delivered instruction, PC, RVC flag
interface instr_aligner_if;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        fetch_req_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_ack_i;
    logic [31:0] fetch_data_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_is_c_o;
    logic        instr_ready_i;

    modport master (
        input  flush_i, flush_pc_i, fetch_ack_i, fetch_data_i, instr_ready_i,
        output fetch_req_o, fetch_addr_o, instr_valid_o, instr_o, instr_pc_o,
        instr_is_c_o
    );

    modport slave (
        output flush_i, flush_pc_i, fetch_ack_i, fetch_data_i, instr_ready_i,
        input  fetch_req_o, fetch_addr_o, instr_valid_o, instr_o, instr_pc_o,
        instr_is_c_o
    );
endinterface

// File: rtl/instr_aligner.sv
// instr_aligner
//   Fetch-side aligner for an RV32C frontend. Issues word-aligned fetches,
//   keeps up to three 16-bit halfwords and hands one whole instruction
//   (16-bit compressed or 32-bit, possibly straddling two words) per
//   handshake to decode, together with its PC and compressed flag.
//   Ports:
//     clk_i  clock
//     rst_i  asynchronous active-high reset
//     bus    instr_aligner_if.master (fetch bus, redirect, decode handshake)
//   Parameter:
//     RESET_PC  PC of the first instruction after reset (bit 0 ignored)
module instr_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic             clk_i,
    input logic             rst_i,
    instr_aligner_if.master bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]  r_state;
    logic [15:0] r_buf [3];
    logic [1:0]  r_cnt;
    logic        r_skip;        // next accepted word starts at its upper half
    logic [31:0] r_fetch_addr;  // next address to fetch (redirect target in DISCARD)
    logic [31:0] r_hold_addr;   // address of the in-flight request being discarded
    logic [31:0] r_pc;

    logic        w_head_c;
    logic        w_valid;
    logic        w_pop;
    logic        w_ack;
    logic        w_push;
    logic [1:0]  w_cnt_pop;
    logic [1:0]  w_cnt_nxt;
    logic [15:0] w_buf_pop [3];
    logic [15:0] w_buf_nxt [3];
    logic [31:0] w_pc_pop;

    assign w_head_c  = (r_buf[0][1:0] != 2'b11);
    assign w_valid   = ((r_cnt >= 2'd1) && w_head_c) || (r_cnt >= 2'd2);
    assign w_pop     = w_valid && bus.instr_ready_i;
    // An ack is only meaningful while a request is on the bus.
    assign w_ack     = bus.fetch_ack_i && (r_state != ST_IDLE);
    assign w_push    = w_ack && (r_state == ST_REQ);
    assign w_pc_pop  = r_pc + (w_head_c ? 32'd2 : 32'd4);

    // Pop first, then append the returned halfwords behind what is left.
    // A request is only issued with at most one halfword left after pop,
    // so a two-halfword push never overflows the three entries.
    always_comb begin
        w_cnt_pop = r_cnt;
        w_buf_pop = r_buf;
        if (w_pop) begin
            if (w_head_c) begin
                w_cnt_pop    = r_cnt - 2'd1;
                w_buf_pop[0] = r_buf[1];
                w_buf_pop[1] = r_buf[2];
            end else begin
                w_cnt_pop    = r_cnt - 2'd2;
                w_buf_pop[0] = r_buf[2];
            end
        end

        w_cnt_nxt = w_cnt_pop;
        w_buf_nxt = w_buf_pop;
        if (w_push) begin
            if (r_skip) begin
                for (int i = 0; i < 3; i++) begin
                    if (2'(i) == w_cnt_pop) w_buf_nxt[i] = bus.fetch_data_i[31:16];
                end
                w_cnt_nxt = w_cnt_pop + 2'd1;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (2'(i) == w_cnt_pop)
                        w_buf_nxt[i] = bus.fetch_data_i[15:0];
                    else if (3'(i) == ({1'b0, w_cnt_pop} + 3'd1))
                        w_buf_nxt[i] = bus.fetch_data_i[31:16];
                end
                w_cnt_nxt = w_cnt_pop + 2'd2;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 2'd0;
            for (int i = 0; i < 3; i++) r_buf[i] <= 16'h0;
            r_skip       <= RESET_PC[1];
            r_fetch_addr <= RESET_PC & ~32'h3;
            r_hold_addr  <= RESET_PC & ~32'h3;
            r_pc         <= RESET_PC & ~32'h1;
        end else if (bus.flush_i) begin
            // Redirect overrides push and pop; any data acked now is stale.
            r_cnt        <= 2'd0;
            r_pc         <= bus.flush_pc_i & ~32'h1;
            r_fetch_addr <= bus.flush_pc_i & ~32'h3;
            r_skip       <= bus.flush_pc_i[1];
            case (r_state)
                ST_REQ: begin
                    if (w_ack) begin
                        r_state <= ST_REQ;
                    end else begin
                        // Keep the old request on the bus until it completes.
                        r_state     <= ST_DISCARD;
                        r_hold_addr <= r_fetch_addr;
                    end
                end
                ST_DISCARD: r_state <= w_ack ? ST_REQ : ST_DISCARD;
                default:    r_state <= ST_REQ;
            endcase
        end else begin
            r_cnt <= w_cnt_nxt;
            r_buf <= w_buf_nxt;
            if (w_pop) r_pc <= w_pc_pop;
            case (r_state)
                ST_IDLE: begin
                    if (w_cnt_pop <= 2'd1) r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (w_ack) begin
                        r_state      <= ST_IDLE;
                        r_fetch_addr <= r_fetch_addr + 32'd4;
                        r_skip       <= 1'b0;
                    end
                end
                ST_DISCARD: begin
                    if (w_ack) r_state <= ST_REQ;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.fetch_req_o   = (r_state != ST_IDLE);
    assign bus.fetch_addr_o  = (r_state == ST_DISCARD) ? r_hold_addr : r_fetch_addr;
    assign bus.instr_valid_o = w_valid;
    assign bus.instr_o       = w_head_c ? {16'h0, r_buf[0]} : {r_buf[1], r_buf[0]};
    assign bus.instr_pc_o    = r_pc;
    assign bus.instr_is_c_o  = w_head_c;

endmodule
